dctq_sched: RTL and testbench



---
 rtl/dctq_sched_pkg.sv | 15 +
 rtl/dctq_bank_tracker.sv | 62 ++++++
 rtl/dctq_sched.sv | 136 +++++++++++++
 tb/tb_dctq_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dctq_sched_pkg.sv
// Shared types and constants for the DCTQ block scheduler.
// Holds the FSM state encoding and the block and bank geometry.
package dctq_sched_pkg;

    localparam int unsigned BLK_COEFS = 64;
    localparam int unsigned NBANKS    = 2;
    localparam int unsigned IDX_W     = $clog2(BLK_COEFS);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN
    } state_t;

endpackage

// File: rtl/dctq_bank_tracker.sv
// Occupancy tracking for the two input-RAM banks.
// Hands the loader its next bank and the core its read bank, and flags overflow.
module dctq_bank_tracker
    import dctq_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_done,
    input  logic              blk_done,
    output logic [NBANKS-1:0] full,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              buf_full,
    output logic              ovf_err
);

    logic [NBANKS-1:0] full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ovf_d     = ovf_q;
        if (wr_done) begin
            if (&full_q) begin
                ovf_d = 1'b1;
            end else begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // A simultaneous set always targets the other bank, so both land.
        if (blk_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ovf_q     <= ovf_d;
        end
    end

    assign full     = full_q;
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign buf_full = &full_q;
    assign ovf_err  = ovf_q;

endmodule

// File: rtl/dctq_sched.sv
// DCTQ block scheduler: launches the core on a full bank, checks the 64
// zig-zag coefficient addresses of each block and releases the bank.
module dctq_sched
    import dctq_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_done,
    output logic             wr_bank,
    output logic             buf_full,
    input  logic             core_ready,
    output logic             core_start,
    output logic             rd_bank,
    input  logic             dctq_valid,
    input  logic [IDX_W-1:0] dctq_addr,
    input  logic             out_afull,
    output logic             core_hold,
    output logic             blk_done,
    output logic [CNT_W-1:0] blk_count,
    output logic             seq_err,
    output logic             ovf_err,
    output logic             tmo_err,
    output logic             busy
);

    localparam int unsigned TMO_W = $clog2(TMO + 1);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               seq_q, seq_d;
    logic               tmo_err_q, tmo_err_d;
    logic               hold_q;
    logic [NBANKS-1:0]  full;

    // Fed with the next-state pulse so the bank frees in the same cycle
    // blk_done is seen, keeping IDLE from relaunching the finished bank.
    dctq_bank_tracker u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_done  (wr_done),
        .blk_done (done_d),
        .full     (full),
        .wr_bank  (wr_bank),
        .rd_bank  (rd_bank),
        .buf_full (buf_full),
        .ovf_err  (ovf_err)
    );

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        seq_d     = seq_q;
        tmo_err_d = tmo_err_q;
        if (dctq_valid && state_q != RUN) begin
            seq_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (full[rd_bank] && core_ready) begin
                    state_d   = LAUNCH;
                    tmo_cnt_d = '0;
                end
            end
            LAUNCH: begin
                if (!core_ready) begin
                    state_d = RUN;
                end else if (tmo_cnt_q == TMO_W'(TMO)) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (dctq_valid) begin
                    if (dctq_addr != idx_q) begin
                        seq_d = 1'b1;
                    end
                    if (idx_q == IDX_W'(BLK_COEFS - 1)) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_q == IDLE) && (state_d == LAUNCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            seq_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            done_q    <= done_d;
            seq_q     <= seq_d;
            tmo_err_q <= tmo_err_d;
            hold_q    <= out_afull;
        end
    end

    assign core_start = start_q;
    assign blk_done   = done_q;
    assign blk_count  = cnt_q;
    assign seq_err    = seq_q;
    assign tmo_err    = tmo_err_q;
    assign core_hold  = hold_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dctq_sched.sv
// Directed bench for dctq_sched: single block, back-to-back banks, overflow,
// launch timeout, sequence errors and reset in the middle of a block.
module tb_dctq_sched;

    logic        clk;
    logic        reset;
    logic        wr_done;
    logic        wr_bank;
    logic        buf_full;
    logic        core_ready;
    logic        core_start;
    logic        rd_bank;
    logic        dctq_valid;
    logic [5:0]  dctq_addr;
    logic        out_afull;
    logic        core_hold;
    logic        blk_done;
    logic [15:0] blk_count;
    logic        seq_err;
    logic        ovf_err;
    logic        tmo_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dctq_sched #(.CNT_W(16), .TMO(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_done    (wr_done),
        .wr_bank    (wr_bank),
        .buf_full   (buf_full),
        .core_ready (core_ready),
        .core_start (core_start),
        .rd_bank    (rd_bank),
        .dctq_valid (dctq_valid),
        .dctq_addr  (dctq_addr),
        .out_afull  (out_afull),
        .core_hold  (core_hold),
        .blk_done   (blk_done),
        .blk_count  (blk_count),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err),
        .tmo_err    (tmo_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_wr();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    // Drives the 64 coefficient strobes; core_ready rises with the last one.
    task automatic run_block(input int bad_idx, input logic [5:0] bad_addr);
        for (int i = 0; i < 64; i++) begin
            dctq_valid = 1'b1;
            dctq_addr  = (i == bad_idx) ? bad_addr : 6'(i);
            if (i == 63) begin
                core_ready = 1'b1;
                chk("blk_done_early", 32'(blk_done), 32'h0);
            end
            tick();
        end
        dctq_valid = 1'b0;
        dctq_addr  = '0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_done    = 1'b0;
        core_ready = 1'b1;
        dctq_valid = 1'b0;
        dctq_addr  = '0;
        out_afull  = 1'b0;
        tick();
        tick();
        chk("rst_wr_bank",  32'(wr_bank),    32'h0);
        chk("rst_rd_bank",  32'(rd_bank),    32'h0);
        chk("rst_buf_full", 32'(buf_full),   32'h0);
        chk("rst_start",    32'(core_start), 32'h0);
        chk("rst_count",    32'(blk_count),  32'h0);
        chk("rst_busy",     32'(busy),       32'h0);
        chk("rst_errs",     {29'h0, seq_err, ovf_err, tmo_err}, 32'h0);
        reset = 1'b0;
        tick();

        // Single block into bank 0
        pulse_wr();
        chk("sb_full",      32'(dut.u_bank.full_q), 32'h1);
        chk("sb_wr_bank",   32'(wr_bank),    32'h1);
        chk("sb_start_n1",  32'(core_start), 32'h0);
        tick();
        chk("sb_start",     32'(core_start), 32'h1);
        chk("sb_busy",      32'(busy),       32'h1);
        chk("sb_rd_bank",   32'(rd_bank),    32'h0);
        core_ready = 1'b0;
        tick();
        chk("sb_start_off", 32'(core_start), 32'h0);
        run_block(-1, 6'h0);
        chk("sb_done",      32'(blk_done),   32'h1);
        chk("sb_count",     32'(blk_count),  32'h1);
        chk("sb_idle",      32'(busy),       32'h0);
        chk("sb_rd_toggle", 32'(rd_bank),    32'h1);
        chk("sb_full_clr",  32'(dut.u_bank.full_q), 32'h0);
        chk("sb_seq_ok",    32'(seq_err),    32'h0);
        tick();
        chk("sb_done_off",  32'(blk_done),   32'h0);
        chk("sb_no_start",  32'(core_start), 32'h0);

        // core_hold latency
        out_afull = 1'b1;
        chk("hold_lat",     32'(core_hold),  32'h0);
        tick();
        chk("hold_on",      32'(core_hold),  32'h1);
        out_afull = 1'b0;
        tick();
        chk("hold_off",     32'(core_hold),  32'h0);

        // Back-to-back: bank 1 then bank 0, plus overflow
        pulse_wr();
        tick();
        chk("bb_start1",    32'(core_start), 32'h1);
        chk("bb_rd1",       32'(rd_bank),    32'h1);
        core_ready = 1'b0;
        tick();
        tick();
        tick();
        pulse_wr();
        chk("bb_buf_full",  32'(buf_full),   32'h1);
        chk("bb_wr_bank",   32'(wr_bank),    32'h1);
        pulse_wr();
        chk("ovf_err",      32'(ovf_err),    32'h1);
        chk("ovf_wr_bank",  32'(wr_bank),    32'h1);
        chk("ovf_full",     32'(dut.u_bank.full_q), 32'h3);
        run_block(-1, 6'h0);
        chk("bb_done1",     32'(blk_done),   32'h1);
        chk("bb_count2",    32'(blk_count),  32'h2);
        chk("bb_rd0",       32'(rd_bank),    32'h0);
        chk("bb_not_full",  32'(buf_full),   32'h0);
        tick();
        chk("bb_start2",    32'(core_start), 32'h1);
        core_ready = 1'b0;
        tick();
        run_block(-1, 6'h0);
        chk("bb_count3",    32'(blk_count),  32'h3);
        chk("bb_rd1b",      32'(rd_bank),    32'h1);
        chk("bb_ovf_stick", 32'(ovf_err),    32'h1);
        chk("bb_full_clr",  32'(dut.u_bank.full_q), 32'h0);

        // Launch timeout with TMO=8, then retry
        pulse_wr();
        tick();
        chk("to_start",     32'(core_start), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("to_pending",   32'(tmo_err),    32'h0);
        chk("to_busy",      32'(busy),       32'h1);
        tick();
        chk("to_err",       32'(tmo_err),    32'h1);
        chk("to_idle",      32'(busy),       32'h0);
        chk("to_start_n",   32'(core_start), 32'h0);
        tick();
        chk("to_retry",     32'(core_start), 32'h1);
        core_ready = 1'b0;
        tick();

        // Sequence error: addr 5 where 6 is expected
        run_block(6, 6'd5);
        chk("se_seq_err",   32'(seq_err),    32'h1);
        chk("se_done",      32'(blk_done),   32'h1);
        chk("se_count",     32'(blk_count),  32'h4);
        chk("se_rd0",       32'(rd_bank),    32'h0);

        // Reset after 30 valids of a block
        pulse_wr();
        tick();
        chk("rr_start",     32'(core_start), 32'h1);
        core_ready = 1'b0;
        tick();
        for (int i = 0; i < 30; i++) begin
            dctq_valid = 1'b1;
            dctq_addr  = 6'(i);
            tick();
        end
        dctq_valid = 1'b0;
        reset      = 1'b1;
        #1;
        chk("rr_busy",      32'(busy),       32'h0);
        chk("rr_count",     32'(blk_count),  32'h0);
        chk("rr_errs",      {29'h0, seq_err, ovf_err, tmo_err}, 32'h0);
        chk("rr_banks",     {30'h0, wr_bank, rd_bank}, 32'h0);
        chk("rr_full",      32'(dut.u_bank.full_q), 32'h0);
        tick();
        reset      = 1'b0;
        core_ready = 1'b1;
        tick();
        pulse_wr();
        tick();
        chk("rr_start2",    32'(core_start), 32'h1);
        chk("rr_rd_bank",   32'(rd_bank),    32'h0);
        core_ready = 1'b0;
        tick();
        run_block(-1, 6'h0);
        chk("rr_done",      32'(blk_done),   32'h1);
        chk("rr_count1",    32'(blk_count),  32'h1);
        chk("rr_seq_ok",    32'(seq_err),    32'h0);

        // Stray valid while idle
        tick();
        dctq_valid = 1'b1;
        tick();
        dctq_valid = 1'b0;
        chk("idle_valid",   32'(seq_err),    32'h1);
        chk("idle_busy",    32'(busy),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
